// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache refill engine.
`timescale 1ns/1ps
package icache_pkg;

  localparam int unsigned ICACHE_LINE_BYTES = 32;
  localparam int unsigned ICACHE_SETS       = 128;
  localparam int unsigned ICACHE_WAYS       = 2;
  localparam int unsigned TAG_W             = 20;
  localparam int unsigned BEATS_PER_LINE    = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StTag
  } state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill: one 8-beat AXI4 INCR read per miss, 32-bit beats packed
// into 64-bit data RAM words, followed by a single tag RAM write and a done pulse.
`timescale 1ns/1ps
module icache_refill
  import icache_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refill_req_i,
  input  logic [31:0] refill_addr_i,
  input  logic        refill_way_i,
  output logic        refill_ack_o,
  output logic        refill_busy_o,
  output logic        refill_done_o,
  output logic        refill_error_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o,
  output logic [9:0]  data_ram_addr_o,
  output logic [63:0] data_ram_data_o,
  output logic        data_ram_wr_o,
  output logic [6:0]  tag_ram_addr_o,
  output logic [20:0] tag_ram_data_o,
  output logic        tag_ram_wr_o
);

  state_e      state_q;
  logic [26:0] line_q;   // addr[31:5]: {tag, set}
  logic        way_q;
  logic [2:0]  cnt_q;
  logic [31:0] low_q;
  logic        err_q;

  logic beat;
  logic beat_last;
  logic beat_err;
  logic unused_addr;

  assign unused_addr = ^refill_addr_i[4:0];

  assign beat      = (state_q == StData) && axi_rvalid_i;
  // Beat 7 always ends the burst; an rlast before it cuts the burst short.
  assign beat_last = (cnt_q == 3'd7) || axi_rlast_i;
  // Bad response, rlast missing on beat 7, or rlast arriving early.
  assign beat_err  = (axi_rresp_i != AXI_RESP_OKAY) || ((cnt_q == 3'd7) != axi_rlast_i);

  // Refill FSM with beat counter, low-half capture and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      line_q  <= '0;
      way_q   <= 1'b0;
      cnt_q   <= '0;
      low_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (refill_req_i) begin
            line_q  <= refill_addr_i[31:5];
            way_q   <= refill_way_i;
            err_q   <= 1'b0;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (axi_arready_i) begin
            cnt_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (beat) begin
            if (!cnt_q[0]) low_q <= axi_rdata_i;
            cnt_q <= cnt_q + 3'd1;
            if (beat_err) err_q <= 1'b1;
            if (beat_last) state_q <= StTag;
          end
        end
        StTag: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    refill_ack_o   = (state_q == StIdle) && refill_req_i;
    refill_busy_o  = (state_q != StIdle);
    axi_arvalid_o  = (state_q == StAddr);
    axi_araddr_o   = axi_arvalid_o ? {line_q, 5'b0} : 32'h0;
    axi_arid_o     = AXI_ID;
    axi_arlen_o    = 8'(BEATS_PER_LINE - 1);
    axi_arburst_o  = AXI_BURST_INCR;
    axi_rready_o   = (state_q == StData);
    tag_ram_wr_o   = (state_q == StTag);
    refill_done_o  = tag_ram_wr_o;
    refill_error_o = tag_ram_wr_o && err_q;
    tag_ram_addr_o = tag_ram_wr_o ? line_q[6:0] : 7'h0;
    tag_ram_data_o = tag_ram_wr_o ? {~err_q, line_q[26 -: TAG_W]} : 21'h0;
  end

  // Data RAM write on every odd beat, combinational with the accepted beat.
  always_comb begin
    data_ram_wr_o   = beat && cnt_q[0];
    data_ram_addr_o = data_ram_wr_o ? {way_q, line_q[6:0], cnt_q[2:1]} : 10'h0;
    data_ram_data_o = data_ram_wr_o ? {axi_rdata_i, low_q} : 64'h0;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Line-refill engine for the instruction cache, and the write-side master of the icache data RAM (1024 x 64-bit, single port, read-first).
- On a miss request it issues one AXI4 INCR read burst for a 32-byte line.
- It packs pairs of 32-bit beats into 64-bit words, writes them into the selected way of the data RAM, then writes the tag entry and reports completion to the fetch pipeline.

Parameters:
AXI_ID, 4'd0, value driven on axi_arid_o; responses with other rid are not expected (not checked).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
refill_req_i  input  1  miss request (level; held until ack)
refill_addr_i  input  32  miss fetch address
refill_way_i  input  1  victim way
refill_ack_o  output  1  one-cycle pulse: request accepted
refill_busy_o  output  1  refill in progress
refill_done_o  output  1  one-cycle pulse: line complete
refill_error_o  output  1  valid with done: bus error occurred
axi_arvalid_o  output  1  AR valid
axi_araddr_o  output  32  line-aligned address
axi_arid_o  output  4  = AXI_ID
axi_arlen_o  output  8  constant 7
axi_arburst_o  output  2  constant 2'b01 (INCR)
axi_arready_i  input  1  AR ready
axi_rvalid_i  input  1  R valid
axi_rdata_i  input  32  R data
axi_rresp_i  input  2  R response
axi_rlast_i  input  1  R last
axi_rready_o  output  1  R ready
data_ram_addr_o  output  10  {way, set[6:0], word[1:0]}
data_ram_data_o  output  64  packed word
data_ram_wr_o  output  1  data RAM write strobe
tag_ram_addr_o  output  7  set index
tag_ram_data_o  output  21  {valid, tag[19:0]}
tag_ram_wr_o  output  1  tag RAM write strobe

Behaviour:
- Address split: tag = addr[31:12], set = addr[11:5], word = addr[4:3].
- FSM states: IDLE, ADDR, DATA, TAG.
- Reset: state IDLE; all outputs 0 except constants arlen = 7 and arburst = 01; beat counter, low-half register and error flag cleared.
- Reset mid-operation returns to IDLE immediately. No partial tag write occurs. The interconnect shares rst_n.
- IDLE: if refill_req_i is high, pulse refill_ack_o, latch addr[31:5] and way, clear error flag, go to ADDR. busy_o is 1 in every state except IDLE.
- ADDR: axi_arvalid_o = 1 with araddr = {addr[31:5], 5'b0}, held stable until arready. On arvalid & arready go to DATA with beat counter = 0.
- DATA: axi_rready_o = 1 (no backpressure). Each accepted beat (rvalid & rready) does the following:
  - Even beat (cnt[0] = 0): capture rdata into the low-half register.
  - Odd beat: data_ram_wr_o = 1 in the same cycle (combinational strobe). data_ram_data_o = {rdata, low_q}. data_ram_addr_o = {way, set, cnt[2:1]}.
  - cnt increments, 3-bit.
- rresp != 2'b00 on any beat sets the sticky error flag. Remaining beats are still consumed and still written.
- Burst termination:
  - Normal: leave DATA to TAG on the beat with cnt == 7 (whether or not rlast is set); a missing rlast on beat 7 sets error.
  - Early: rlast on a beat with cnt < 7 sets error and goes to TAG; words not yet written are left stale.
- TAG, single cycle: tag_ram_wr_o = 1, tag_ram_addr_o = set, tag_ram_data_o = {~error, tag}. An error therefore invalidates the line. refill_done_o = 1 and refill_error_o = error; return to IDLE.
- Latency, zero-wait bus: ack (cycle 0), AR handshake (cycle 1), beats cycles 2-9, tag write and done at cycle 10. Done is asserted exactly one cycle after the last data RAM write.
- No new request is accepted until the cycle after done. A request arriving while busy stays pending and is acked in the next IDLE cycle.
- rvalid outside DATA is ignored; rready is 0 there.

Decomposition:
- Shared package icache_pkg holds:
  - constants ICACHE_LINE_BYTES = 32, ICACHE_SETS = 128, ICACHE_WAYS = 2, TAG_W = 20, BEATS_PER_LINE = 8, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00;
  - the state encoding enum.
- No sub-module: a single FSM plus a beat counter.

Test Plan:
- Nominal refill, addr 0x0000_1234, way 0, zero-wait, rdata = 0xA0000000+i (i = beat index):
  - AR address 0x0000_1220, len 7, burst 01;
  - data RAM writes at 0x044..0x047, first data 0xA0000001_A0000000, last 0xA0000007_A0000006;
  - tag write at set 0x11 with data {1, 0x00001}; done on cycle 10; error 0.
- arready held low for 5 cycles, way 1, addr 0xFFFF_FFE0: arvalid stays high and araddr stays 0xFFFF_FFE0 throughout; data RAM addresses 0x3FC..0x3FF; tag {1, 0xFFFFF} at set 0x7F.
- rvalid gaps of 0-3 random cycles between beats: exactly 4 data writes with correctly packed words; done follows the last write by 1 cycle.
- rresp = SLVERR on beat 3: all 8 beats accepted and 4 writes performed; tag data valid bit = 0; done with error = 1.
- rlast on beat 5: 3 data writes (words 0-2), tag valid = 0, error = 1; a second request immediately after is acked and completes cleanly.
- rst_n asserted after beat 4: all outputs 0 asynchronously and no tag write; after release a new request refills normally.
